// File: rtl/rom_rr_arbiter_pkg.sv
// Shared types and small helpers for the round-robin ROM arbiter.
// Holds the FSM state encoding plus one-hot and pointer-wrap helpers.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP
  } arb_st_t;

  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    return MAX_REQ'(1) << idx;
  endfunction

  // Modulo wrap keeps the pointer correct for non-power-of-2 requester counts.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rom_rr_arbiter_if.sv
// Bundle of request, ROM and response signals between the clients and the arbiter.
// The arbiter uses the slave modport; the client/ROM side uses master.
interface rom_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [ADDR_W-1:0]         o_rom_sel;
  logic [DATA_W-1:0]         i_rom_dat;
  logic                      o_rsp_vld;
  logic [ID_W-1:0]           o_rsp_id;
  logic [DATA_W-1:0]         o_rsp_dat;
  logic                      i_rsp_rdy;

  modport slave (
    input  i_req, i_addr, i_rom_dat, i_rsp_rdy,
    output o_gnt, o_rom_sel, o_rsp_vld, o_rsp_id, o_rsp_dat
  );

  modport master (
    output i_req, i_addr, i_rom_dat, i_rsp_rdy,
    input  o_gnt, o_rom_sel, o_rsp_vld, o_rsp_id, o_rsp_dat
  );

endinterface

// File: rtl/rom_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester after last_id wins.
// Scanning starts at last_id+1 and wraps modulo NUM_REQ.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_id_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_req_o
);

  logic found;
  int   idx;

  assign any_req_o = |req_i;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = wrap_idx(int'(last_id_i), off, NUM_REQ);
      if (!found && req_i[ID_W'(idx)]) begin
        found    = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Shares one combinational lookup ROM among NUM_REQ clients with round-robin grants.
// Each lookup runs IDLE -> READ -> RESP and returns id-tagged data via valid/ready.
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rom_rr_arbiter_if.slave bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_st_t             state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0]   rom_sel_q, rom_sel_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic [ID_W-1:0]     last_id_q, last_id_d;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
    assign addr_arr[k] = bus.i_addr[k*ADDR_W +: ADDR_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i     (bus.i_req),
    .last_id_i (last_id_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Arbitration happens only in IDLE; READ and RESP ignore new requests.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    rom_sel_d = rom_sel_q;
    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    rsp_dat_d = rsp_dat_q;
    last_id_d = last_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          rom_sel_d = addr_arr[winner];
          rsp_id_d  = winner;
          gnt_d     = NUM_REQ'(onehot(int'(winner)));
          last_id_d = winner;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        rsp_dat_d = bus.i_rom_dat;
        rsp_vld_d = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (bus.i_rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_id resets to the top index so requester 0 wins the first round.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rom_sel_q <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_dat_q <= '0;
      last_id_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rom_sel_q <= rom_sel_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_dat_q <= rsp_dat_d;
      last_id_q <= last_id_d;
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_rom_sel = rom_sel_q;
  assign bus.o_rsp_vld = rsp_vld_q;
  assign bus.o_rsp_id  = rsp_id_q;
  assign bus.o_rsp_dat = rsp_dat_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for back-pressure, address capture and mid-lookup reset.
module tb_rom_rr_arbiter;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] addr;
    logic        rdy;
    logic [3:0]  gnt;
    logic        vld;
    logic [1:0]  id;
    logic [3:0]  dat;
    logic [2:0]  sel;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;
  vec_t vecs[$];

  rom_rr_arbiter_if #(.NUM_REQ(4), .ADDR_W(3), .DATA_W(4)) bus ();

  rom_rr_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (3),
    .DATA_W  (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  function automatic logic [3:0] romModel(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'h9;
      3'd1:    return 4'hB;
      3'd2:    return 4'h2;
      3'd3:    return 4'h3;
      3'd4:    return 4'hE;
      default: return 4'h0;
    endcase
  endfunction

  assign bus.i_rom_dat = romModel(bus.o_rom_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] gnt, input logic vld,
                          input logic [1:0] id, input logic [3:0] dat, input logic [2:0] sel);
    checkOutput({tag, ".gnt"}, 32'(bus.o_gnt), 32'(gnt));
    checkOutput({tag, ".vld"}, 32'(bus.o_rsp_vld), 32'(vld));
    checkOutput({tag, ".id"},  32'(bus.o_rsp_id), 32'(id));
    checkOutput({tag, ".dat"}, 32'(bus.o_rsp_dat), 32'(dat));
    checkOutput({tag, ".sel"}, 32'(bus.o_rom_sel), 32'(sel));
  endtask

  // Drive inputs between edges, then sample #1 after the next rising edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [11:0] addr, input logic rdy);
    bus.i_req     = req;
    bus.i_addr    = addr;
    bus.i_rsp_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.i_req     = '0;
    bus.i_addr    = '0;
    bus.i_rsp_rdy = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [11:0] addr,
                              input logic rdy, input logic [3:0] gnt, input logic vld,
                              input logic [1:0] id, input logic [3:0] dat, input logic [2:0] sel);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.rdy = rdy;
    v.gnt = gnt; v.vld = vld; v.id = id; v.dat = dat; v.sel = sel;
    return v;
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;

    // Lone req0 at addr 4, then four requesters held with addrs 0,1,2,3.
    vecs.push_back(mk(0, 4'b0001, 12'h004, 1, 4'b0001, 0, 2'd0, 4'h0, 3'd4));
    vecs.push_back(mk(0, 4'b0000, 12'h004, 1, 4'b0000, 1, 2'd0, 4'hE, 3'd4));
    vecs.push_back(mk(0, 4'b0000, 12'h004, 1, 4'b0000, 0, 2'd0, 4'hE, 3'd4));
    vecs.push_back(mk(0, 4'b0000, 12'h004, 1, 4'b0000, 0, 2'd0, 4'hE, 3'd4));
    vecs.push_back(mk(1, 4'b1111, 12'h688, 1, 4'b0001, 0, 2'd0, 4'h0, 3'd0));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 1, 2'd0, 4'h9, 3'd0));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 0, 2'd0, 4'h9, 3'd0));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0010, 0, 2'd1, 4'h9, 3'd1));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 1, 2'd1, 4'hB, 3'd1));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 0, 2'd1, 4'hB, 3'd1));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0100, 0, 2'd2, 4'hB, 3'd2));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 1, 2'd2, 4'h2, 3'd2));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 0, 2'd2, 4'h2, 3'd2));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b1000, 0, 2'd3, 4'h2, 3'd3));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 1, 2'd3, 4'h3, 3'd3));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 0, 2'd3, 4'h3, 3'd3));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0001, 0, 2'd0, 4'h3, 3'd0));
    vecs.push_back(mk(0, 4'b1111, 12'h688, 1, 4'b0000, 1, 2'd0, 4'h9, 3'd0));
    vecs.push_back(mk(0, 4'b0000, 12'h688, 1, 4'b0000, 0, 2'd0, 4'h9, 3'd0));

    // Reset state, then ten idle cycles with no requests.
    bus.i_req     = '0;
    bus.i_addr    = '0;
    bus.i_rsp_rdy = 1'b1;
    rst_n = 1'b0;
    #3;
    checkAll("reset", 4'b0000, 0, 2'd0, 4'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0000, 12'h000, 1'b1);
      checkAll($sformatf("idle%0d", i), 4'b0000, 0, 2'd0, 4'h0, 3'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].req, vecs[i].addr, vecs[i].rdy);
      checkAll($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].vld, vecs[i].id,
               vecs[i].dat, vecs[i].sel);
    end

    // Back-pressure: response held while rdy is low, and req0 waits for IDLE.
    doReset();
    applyStimulus(4'b0100, 12'h100, 1'b0);
    checkAll("bp.grant", 4'b0100, 0, 2'd2, 4'h0, 3'd4);
    applyStimulus(4'b0001, 12'h100, 1'b0);
    checkAll("bp.read", 4'b0000, 1, 2'd2, 4'hE, 3'd4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, 12'h100, 1'b0);
      checkAll($sformatf("bp.hold%0d", i), 4'b0000, 1, 2'd2, 4'hE, 3'd4);
    end
    applyStimulus(4'b0001, 12'h100, 1'b1);
    checkAll("bp.xfer", 4'b0000, 0, 2'd2, 4'hE, 3'd4);
    applyStimulus(4'b0001, 12'h100, 1'b1);
    checkAll("bp.next", 4'b0001, 0, 2'd0, 4'hE, 3'd0);
    applyStimulus(4'b0000, 12'h100, 1'b1);
    checkAll("bp.nextrd", 4'b0000, 1, 2'd0, 4'h9, 3'd0);
    applyStimulus(4'b0000, 12'h100, 1'b1);
    checkAll("bp.done", 4'b0000, 0, 2'd0, 4'h9, 3'd0);

    // Address captured at the grant edge; later changes are ignored.
    applyStimulus(4'b0100, 12'h040, 1'b1);
    checkAll("cap.grant", 4'b0100, 0, 2'd2, 4'h9, 3'd1);
    applyStimulus(4'b0000, 12'h1C0, 1'b1);
    checkAll("cap.read", 4'b0000, 1, 2'd2, 4'hB, 3'd1);
    applyStimulus(4'b0000, 12'h1C0, 1'b1);
    checkAll("cap.done", 4'b0000, 0, 2'd2, 4'hB, 3'd1);

    // Reset while a response is pending, then req1 must beat req3.
    applyStimulus(4'b0010, 12'h018, 1'b0);
    checkAll("rst.grant", 4'b0010, 0, 2'd1, 4'hB, 3'd3);
    applyStimulus(4'b0000, 12'h018, 1'b0);
    checkAll("rst.resp", 4'b0000, 1, 2'd1, 4'h3, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("rst.async", 4'b0000, 0, 2'd0, 4'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1010, 12'h420, 1'b1);
    checkAll("rst.win1", 4'b0010, 0, 2'd1, 4'h0, 3'd4);
    applyStimulus(4'b1000, 12'h420, 1'b1);
    checkAll("rst.rd1", 4'b0000, 1, 2'd1, 4'hE, 3'd4);
    applyStimulus(4'b1000, 12'h420, 1'b1);
    checkAll("rst.x1", 4'b0000, 0, 2'd1, 4'hE, 3'd4);
    applyStimulus(4'b1000, 12'h420, 1'b1);
    checkAll("rst.win3", 4'b1000, 0, 2'd3, 4'hE, 3'd2);
    applyStimulus(4'b0000, 12'h420, 1'b1);
    checkAll("rst.rd3", 4'b0000, 1, 2'd3, 4'h2, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
